iob_sram_tdp_arbiter: RTL and testbench

Shares the sky130 1rw1r 32x512 SRAM macro between two native-interface requesters. Reads from requester 0 use the RW port (port 0), and reads from requester 1 use the read-only port (port 1). All writes go through port 0. Partial-strobe writes are done as read-modify-write because the macro wrapper ties its write mask to all ones. The block sits between the SoC memory masters and the SRAM macro instance.

---
 rtl/iob_sram_tdp_arbiter.sv | 173 +++++++++++++++++
 tb/tb_iob_sram_tdp_arbiter.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/iob_sram_tdp_arbiter.sv
// Two-requester arbiter for the sky130 1rw1r 32x512 SRAM macro.
// Port 0 serves r0 accesses and r1 writes; port 1 serves r1 reads.
module iob_sram_tdp_arbiter #(
  parameter int ADDR_W = 9,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              arst_n,
  input  logic              r0_valid,
  input  logic [ADDR_W-1:0] r0_addr,
  input  logic [DATA_W-1:0] r0_wdata,
  input  logic [DATA_W/8-1:0] r0_wstrb,
  output logic [DATA_W-1:0] r0_rdata,
  output logic              r0_ready,
  input  logic              r1_valid,
  input  logic [ADDR_W-1:0] r1_addr,
  input  logic [DATA_W-1:0] r1_wdata,
  input  logic [DATA_W/8-1:0] r1_wstrb,
  output logic [DATA_W-1:0] r1_rdata,
  output logic              r1_ready,
  output logic              sram_csb0,
  output logic              sram_web0,
  output logic [ADDR_W-1:0] sram_addr0,
  output logic [DATA_W-1:0] sram_din0,
  input  logic [DATA_W-1:0] sram_dout0,
  output logic              sram_csb1,
  output logic [ADDR_W-1:0] sram_addr1,
  input  logic [DATA_W-1:0] sram_dout1
);

  localparam int SW = DATA_W / 8;

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] RD     = 2'd1;
  localparam logic [1:0] WR     = 2'd2;
  localparam logic [1:0] RMW_WR = 2'd3;

  localparam logic P1_IDLE = 1'b0;
  localparam logic P1_RD   = 1'b1;

  logic [1:0]        p0State;
  logic [1:0]        p0Next;
  logic              p1State;
  logic              lastGrant;
  logic              curReq;
  logic [ADDR_W-1:0] curAddr;
  logic [DATA_W-1:0] curData;
  logic [SW-1:0]     curStrb;

  logic              cand0;
  logic              cand1;
  logic              grant;
  logic              issue0;
  logic              fullWr;
  logic [ADDR_W-1:0] gAddr;
  logic [DATA_W-1:0] gData;
  logic [SW-1:0]     gStrb;
  logic              p0WrHit;
  logic              p1Issue;
  logic              r0Done;
  logic              r1Done;

  function automatic logic [DATA_W-1:0] merge(
    input logic [DATA_W-1:0] oldW,
    input logic [DATA_W-1:0] newW,
    input logic [SW-1:0]     strb
  );
    merge = oldW;
    for (int k = 0; k < SW; k++) begin
      if (strb[k]) merge[8*k +: 8] = newW[8*k +: 8];
    end
  endfunction

  // Gating with arst_n keeps the macro deselected while reset is held.
  always_comb begin
    cand0  = arst_n & r0_valid & ~r0_ready;
    cand1  = arst_n & r1_valid & ~r1_ready & (|r1_wstrb);
    grant  = (cand0 & cand1) ? ~lastGrant : cand1;
    issue0 = (p0State == IDLE) & (cand0 | cand1);
    gAddr  = grant ? r1_addr  : r0_addr;
    gData  = grant ? r1_wdata : r0_wdata;
    gStrb  = grant ? r1_wstrb : r0_wstrb;
    fullWr = &gStrb;
  end

  always_comb begin
    sram_csb0  = 1'b1;
    sram_web0  = 1'b1;
    sram_addr0 = '0;
    sram_din0  = '0;
    unique case (1'b1)
      issue0: begin
        sram_csb0  = 1'b0;
        sram_addr0 = gAddr;
        if (fullWr) begin
          sram_web0 = 1'b0;
          sram_din0 = gData;
        end
      end
      (p0State == RMW_WR): begin
        sram_csb0  = 1'b0;
        sram_web0  = 1'b0;
        sram_addr0 = curAddr;
        sram_din0  = merge(sram_dout0, curData, curStrb);
      end
      default: ;
    endcase
  end

  // A port-1 read waits while port 0 writes the same word.
  always_comb begin
    p0WrHit = (issue0 & fullWr & (gAddr == r1_addr))
            | ((p0State == RMW_WR) & (curAddr == r1_addr));
    p1Issue = arst_n & (p1State == P1_IDLE)
            & r1_valid & ~r1_ready & ~(|r1_wstrb) & ~p0WrHit;
    sram_csb1  = ~p1Issue;
    sram_addr1 = p1Issue ? r1_addr : '0;
  end

  always_comb begin
    p0Next = IDLE;
    unique case (p0State)
      IDLE: begin
        if (issue0) begin
          if (fullWr) p0Next = WR;
          else if (|gStrb) p0Next = RMW_WR;
          else p0Next = RD;
        end
      end
      default: p0Next = IDLE;
    endcase
  end

  always_comb begin
    r0Done = (p0State == RD)
           | (issue0 & fullWr & ~grant)
           | ((p0State == RMW_WR) & ~curReq);
    r1Done = (p1State == P1_RD)
           | (issue0 & fullWr & grant)
           | ((p0State == RMW_WR) & curReq);
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      p0State   <= IDLE;
      p1State   <= P1_IDLE;
      lastGrant <= 1'b1;
      curReq    <= 1'b0;
      curAddr   <= '0;
      curData   <= '0;
      curStrb   <= '0;
      r0_ready  <= 1'b0;
      r1_ready  <= 1'b0;
      r0_rdata  <= '0;
      r1_rdata  <= '0;
    end else begin
      p0State  <= p0Next;
      p1State  <= p1Issue ? P1_RD : P1_IDLE;
      r0_ready <= r0Done;
      r1_ready <= r1Done;
      if (issue0) begin
        lastGrant <= grant;
        curReq    <= grant;
        curAddr   <= gAddr;
        curData   <= gData;
        curStrb   <= gStrb;
      end
      if (p0State == RD) r0_rdata <= sram_dout0;
      if (p1State == P1_RD) r1_rdata <= sram_dout1;
    end
  end

endmodule

// File: tb/tb_iob_sram_tdp_arbiter.sv
// Directed bench for iob_sram_tdp_arbiter with a behavioural
// 1rw1r SRAM model attached to the macro pins.
module tb_iob_sram_tdp_arbiter;

  logic        clk = 1'b0;
  logic        arst_n = 1'b0;
  logic        r0_valid, r1_valid;
  logic [8:0]  r0_addr, r1_addr;
  logic [31:0] r0_wdata, r1_wdata;
  logic [3:0]  r0_wstrb, r1_wstrb;
  logic [31:0] r0_rdata, r1_rdata;
  logic        r0_ready, r1_ready;
  logic        sram_csb0, sram_web0, sram_csb1;
  logic [8:0]  sram_addr0, sram_addr1;
  logic [31:0] sram_din0, sram_dout0, sram_dout1;

  logic [31:0] mem [0:511];
  logic        preEn = 1'b0;
  logic [8:0]  preAddr = '0;
  logic [31:0] preData = '0;

  int nChecks = 0;
  int nFails = 0;
  int order[$];

  always #5 clk = ~clk;

  iob_sram_tdp_arbiter dut (
    .clk(clk), .arst_n(arst_n),
    .r0_valid(r0_valid), .r0_addr(r0_addr), .r0_wdata(r0_wdata),
    .r0_wstrb(r0_wstrb), .r0_rdata(r0_rdata), .r0_ready(r0_ready),
    .r1_valid(r1_valid), .r1_addr(r1_addr), .r1_wdata(r1_wdata),
    .r1_wstrb(r1_wstrb), .r1_rdata(r1_rdata), .r1_ready(r1_ready),
    .sram_csb0(sram_csb0), .sram_web0(sram_web0),
    .sram_addr0(sram_addr0), .sram_din0(sram_din0),
    .sram_dout0(sram_dout0), .sram_csb1(sram_csb1),
    .sram_addr1(sram_addr1), .sram_dout1(sram_dout1)
  );

  always @(posedge clk) begin
    if (preEn) mem[preAddr] <= preData;
    if (!sram_csb0) begin
      if (!sram_web0) mem[sram_addr0] <= sram_din0;
      else sram_dout0 <= mem[sram_addr0];
    end
    if (!sram_csb1) sram_dout1 <= mem[sram_addr1];
  end

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    nChecks++;
    if (got !== exp) begin
      nFails++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic preload(input logic [8:0] a, input logic [31:0] d);
    @(negedge clk);
    preEn = 1'b1; preAddr = a; preData = d;
    @(negedge clk);
    preEn = 1'b0;
  endtask

  task automatic waitRdy(input int who, input int expLat, input string tag);
    int n;
    logic rdy;
    n = 0;
    rdy = 1'b0;
    while (!rdy && n < 20) begin
      @(negedge clk); #1;
      n++;
      rdy = (who == 0) ? r0_ready : r1_ready;
    end
    check({tag, "_rdy"}, 32'(rdy), 32'd1);
    if (expLat >= 0) check({tag, "_lat"}, 32'(n), 32'(expLat));
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

  initial begin
    r0_valid = 1'b1; r0_addr = 9'd3; r0_wdata = 32'h1; r0_wstrb = 4'hF;
    r1_valid = 1'b0; r1_addr = '0; r1_wdata = '0; r1_wstrb = '0;

    // reset values while a request is pending
    repeat (2) @(negedge clk);
    #1;
    check("rst_csb0", 32'(sram_csb0), 32'd1);
    check("rst_csb1", 32'(sram_csb1), 32'd1);
    check("rst_web0", 32'(sram_web0), 32'd1);
    check("rst_addr0", 32'(sram_addr0), 32'd0);
    check("rst_addr1", 32'(sram_addr1), 32'd0);
    check("rst_din0", sram_din0, 32'd0);
    check("rst_rdy0", 32'(r0_ready), 32'd0);
    check("rst_rdy1", 32'(r1_ready), 32'd0);
    check("rst_rdata0", r0_rdata, 32'd0);
    check("rst_rdata1", r1_rdata, 32'd0);
    r0_valid = 1'b0; r0_wstrb = '0;
    @(negedge clk);
    arst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); #1;
      check("idle_csb0", 32'(sram_csb0), 32'd1);
      check("idle_csb1", 32'(sram_csb1), 32'd1);
    end

    // full write then read back
    @(negedge clk);
    r0_addr = 9'd5; r0_wdata = 32'hDEADBEEF; r0_wstrb = 4'hF; r0_valid = 1'b1;
    #1;
    check("wr_csb0", 32'(sram_csb0), 32'd0);
    check("wr_web0", 32'(sram_web0), 32'd0);
    check("wr_addr0", 32'(sram_addr0), 32'd5);
    check("wr_din0", sram_din0, 32'hDEADBEEF);
    waitRdy(0, 1, "wr");
    r0_valid = 1'b0; r0_wstrb = '0;
    @(negedge clk); #1;
    check("wr_pulse", 32'(r0_ready), 32'd0);
    check("wr_mem", mem[5], 32'hDEADBEEF);

    @(negedge clk);
    r0_addr = 9'd5; r0_wstrb = '0; r0_valid = 1'b1;
    #1;
    check("rd_csb0", 32'(sram_csb0), 32'd0);
    check("rd_web0", 32'(sram_web0), 32'd1);
    waitRdy(0, 2, "rd");
    check("rd_data", r0_rdata, 32'hDEADBEEF);
    r0_valid = 1'b0;

    // partial write from r1
    preload(9'd7, 32'h11223344);
    @(negedge clk);
    r1_addr = 9'd7; r1_wdata = 32'hAABBCCDD; r1_wstrb = 4'b0101; r1_valid = 1'b1;
    #1;
    check("rmw_rd_csb0", 32'(sram_csb0), 32'd0);
    check("rmw_rd_web0", 32'(sram_web0), 32'd1);
    check("rmw_rd_addr0", 32'(sram_addr0), 32'd7);
    check("rmw_csb1", 32'(sram_csb1), 32'd1);
    @(negedge clk); #1;
    check("rmw_wr_csb0", 32'(sram_csb0), 32'd0);
    check("rmw_wr_web0", 32'(sram_web0), 32'd0);
    check("rmw_wr_din0", sram_din0, 32'h11BB33DD);
    check("rmw_early", 32'(r1_ready), 32'd0);
    waitRdy(1, 1, "rmw");
    r1_valid = 1'b0; r1_wstrb = '0;
    @(negedge clk);
    check("rmw_mem", mem[7], 32'h11BB33DD);

    // contention: r0 reads, r1 full-writes, four rounds each
    @(negedge clk);
    fork
      begin
        for (int i = 0; i < 4; i++) begin
          r0_addr = 9'd5; r0_wstrb = '0; r0_valid = 1'b1;
          waitRdy(0, -1, "cont0");
          order.push_back(0);
          check("cont0_data", r0_rdata, 32'hDEADBEEF);
          r0_valid = 1'b0;
          @(negedge clk);
        end
      end
      begin
        for (int i = 0; i < 4; i++) begin
          r1_addr = 9'(20 + i); r1_wdata = 32'h10000000 + 32'(i);
          r1_wstrb = 4'hF; r1_valid = 1'b1;
          waitRdy(1, -1, "cont1");
          order.push_back(1);
          r1_valid = 1'b0; r1_wstrb = '0;
          @(negedge clk);
        end
      end
    join
    check("cont_n", 32'(order.size()), 32'd8);
    for (int i = 0; i < order.size(); i++)
      check("cont_order", 32'(order[i]), 32'(i % 2));
    for (int i = 0; i < 4; i++)
      check("cont_mem", mem[20 + i], 32'h10000000 + 32'(i));

    // concurrent reads on both ports
    preload(9'd1, 32'h01010101);
    preload(9'd2, 32'h02020202);
    @(negedge clk);
    r0_addr = 9'd1; r0_wstrb = '0; r0_valid = 1'b1;
    r1_addr = 9'd2; r1_wstrb = '0; r1_valid = 1'b1;
    #1;
    check("cc_csb0", 32'(sram_csb0), 32'd0);
    check("cc_csb1", 32'(sram_csb1), 32'd0);
    check("cc_addr1", 32'(sram_addr1), 32'd2);
    @(negedge clk); #1;
    check("cc_early0", 32'(r0_ready), 32'd0);
    check("cc_early1", 32'(r1_ready), 32'd0);
    @(negedge clk); #1;
    check("cc_rdy0", 32'(r0_ready), 32'd1);
    check("cc_rdy1", 32'(r1_ready), 32'd1);
    check("cc_data0", r0_rdata, 32'h01010101);
    check("cc_data1", r1_rdata, 32'h02020202);
    r0_valid = 1'b0; r1_valid = 1'b0;

    // port-1 read against a same-address RMW write
    preload(9'd9, 32'h55667788);
    @(negedge clk);
    r0_addr = 9'd9; r0_wdata = 32'h99AABBCC; r0_wstrb = 4'b0011; r0_valid = 1'b1;
    #1;
    check("col_rd_web0", 32'(sram_web0), 32'd1);
    @(negedge clk);
    r1_addr = 9'd9; r1_wstrb = '0; r1_valid = 1'b1;
    #1;
    check("col_wr_web0", 32'(sram_web0), 32'd0);
    check("col_wr_din0", sram_din0, 32'h5566BBCC);
    check("col_block", 32'(sram_csb1), 32'd1);
    @(negedge clk); #1;
    check("col_rdy0", 32'(r0_ready), 32'd1);
    check("col_csb1", 32'(sram_csb1), 32'd0);
    check("col_addr1", 32'(sram_addr1), 32'd9);
    r0_valid = 1'b0; r0_wstrb = '0;
    waitRdy(1, 2, "col");
    check("col_data", r1_rdata, 32'h5566BBCC);
    r1_valid = 1'b0;

    // reset while the RMW read is being issued
    preload(9'd12, 32'hCAFEF00D);
    @(negedge clk);
    r0_addr = 9'd12; r0_wdata = 32'h000000AA; r0_wstrb = 4'b0001; r0_valid = 1'b1;
    #1;
    check("rr_csb0", 32'(sram_csb0), 32'd0);
    check("rr_web0", 32'(sram_web0), 32'd1);
    arst_n = 1'b0;
    #1;
    check("rr_desel", 32'(sram_csb0), 32'd1);
    r0_valid = 1'b0; r0_wstrb = '0;
    @(negedge clk); #1;
    check("rr_nordy", 32'(r0_ready), 32'd0);
    @(negedge clk);
    arst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); #1;
      check("rr_post_rdy", 32'(r0_ready), 32'd0);
      check("rr_post_csb0", 32'(sram_csb0), 32'd1);
    end
    check("rr_mem", mem[12], 32'hCAFEF00D);
    @(negedge clk);
    r0_addr = 9'd12; r0_wstrb = '0; r0_valid = 1'b1;
    waitRdy(0, 2, "rr_rd");
    check("rr_data", r0_rdata, 32'hCAFEF00D);
    r0_valid = 1'b0;

    @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", nChecks, nFails);
    $finish;
  end

endmodule
